// File: rtl/entrada_condicionador_if.sv
// Pin-side bundle of entrada_condicionador.
// Raw buttons/sensors in; debounced levels, strobes and test mode out.
interface entrada_condicionador_if;
  logic [3:0] btn_raw;
  logic       btn_test_raw;
  logic [2:0] sns_raw;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level;
  logic [2:0] sns_level;
  logic [2:0] sns_change;
  logic       test;

  modport master (
    output btn_raw, btn_test_raw, sns_raw,
    input  btn_pulse, btn_level, sns_level,
    input  sns_change, test
  );

  modport slave (
    input  btn_raw, btn_test_raw, sns_raw,
    output btn_pulse, btn_level, sns_level,
    output sns_change, test
  );
endinterface

// File: rtl/entrada_condicionador.sv
// Input conditioner: 2-flop sync + debounce for 4 buttons, test button
// and 3 sensors; press pulses, sensor change strobes, long-press test mode.
// Ports: clk, rst (async, active-low), io (entrada_condicionador_if.slave):
//   btn_raw[3:0], btn_test_raw (active-low), sns_raw[2:0] (active-high) in;
//   btn_pulse, btn_level, sns_level, sns_change, test out.
// Optional macro AUTO_REPEAT_EN: auto-repeat pulses on back/next.
module entrada_condicionador #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 5000,
  parameter int REPEAT_MS     = 250
) (
  input logic                    clk,
  input logic                    rst,
  entrada_condicionador_if.slave io
);
  localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int LP_CYC = CLK_HZ / 1000 * LONG_PRESS_MS;
  localparam int RP_CYC = CLK_HZ / 1000 * REPEAT_MS;
  localparam int DBW    = $clog2(DB_CYC + 1);
  localparam int LPW    = $clog2(LP_CYC + 1);
  localparam logic [DBW-1:0] DB_TOP = DBW'(DB_CYC - 1);
  localparam logic [LPW-1:0] LP_TOP = LPW'(LP_CYC - 1);
  // Channel map: [3:0] buttons, [4] test button, [7:5] sensors.
  // Idle value: buttons released (high), sensors low.
  localparam logic [7:0] IDLE_V = 8'b000_1_1111;

  if (DB_CYC < 2 || LP_CYC < 1 || RP_CYC < 1) begin : g_cfg_err
    $error("entrada_condicionador: cycle counts out of range");
  end

  typedef enum logic [1:0] {
    LP_IDLE,
    LP_COUNT,
    LP_HELD
  } lp_e;

  logic [7:0]     raw;
  logic [7:0]     s1_q, s2_q;
  logic [7:0]     stb_q, stb_d;
  logic [DBW-1:0] db_q [8];
  logic [DBW-1:0] db_d [8];
  logic [3:0]     press;
  logic [1:0]     rep;
  logic [3:0]     pulse_q, pulse_d;
  logic [2:0]     chg_q, chg_d;
  lp_e            lp_q, lp_d;
  logic [LPW-1:0] lp_cnt_q, lp_cnt_d;
  logic           test_q, test_d;
  logic           tst_on;

  assign raw = {io.sns_raw, io.btn_test_raw, io.btn_raw};

  // Stable value moves only after DB_CYC consecutive differing cycles.
  always_comb begin
    stb_d = stb_q;
    for (int i = 0; i < 8; i++) begin
      db_d[i] = '0;
      if (s2_q[i] != stb_q[i]) begin
        if (db_q[i] >= DB_TOP) stb_d[i] = s2_q[i];
        else db_d[i] = db_q[i] + DBW'(1);
      end
    end
  end

  // Buttons are active-low on the pins: press = stable 1 -> 0.
  assign press = stb_q[3:0] & ~stb_d[3:0];
  assign chg_d = stb_q[7:5] ^ stb_d[7:5];

`ifdef AUTO_REPEAT_EN
  localparam int RPW = $clog2(RP_CYC + 1);
  localparam logic [RPW-1:0] RP_TOP = RPW'(RP_CYC - 1);

  logic [RPW-1:0] rp_q [2];
  logic [RPW-1:0] rp_d [2];

  // Counts only while held across the edge; release clears it.
  always_comb begin
    rep = '0;
    for (int i = 0; i < 2; i++) begin
      rp_d[i] = '0;
      if (!stb_q[i] && !stb_d[i]) begin
        if (rp_q[i] >= RP_TOP) rep[i] = 1'b1;
        else rp_d[i] = rp_q[i] + RPW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_q[0] <= '0;
      rp_q[1] <= '0;
    end else begin
      rp_q[0] <= rp_d[0];
      rp_q[1] <= rp_d[1];
    end
  end
`else
  assign rep = 2'b00;
`endif

  assign pulse_d = press | {2'b00, rep};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= IDLE_V;
      s2_q    <= IDLE_V;
      stb_q   <= IDLE_V;
      pulse_q <= '0;
      chg_q   <= '0;
      for (int i = 0; i < 8; i++) db_q[i] <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      stb_q   <= stb_d;
      pulse_q <= pulse_d;
      chg_q   <= chg_d;
      for (int i = 0; i < 8; i++) db_q[i] <= db_d[i];
    end
  end

  assign tst_on = ~stb_q[4];

  always_comb begin
    lp_d     = lp_q;
    lp_cnt_d = lp_cnt_q;
    test_d   = test_q;
    unique case (lp_q)
      LP_IDLE: begin
        if (tst_on) begin
          lp_d     = LP_COUNT;
          lp_cnt_d = '0;
        end
      end
      LP_COUNT: begin
        if (!tst_on) begin
          lp_d = LP_IDLE;
        end else if (lp_cnt_q >= LP_TOP) begin
          test_d = ~test_q;
          lp_d   = LP_HELD;
        end else begin
          lp_cnt_d = lp_cnt_q + LPW'(1);
        end
      end
      LP_HELD: begin
        if (!tst_on) lp_d = LP_IDLE;
      end
      default: lp_d = LP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lp_q     <= LP_IDLE;
      lp_cnt_q <= '0;
      test_q   <= 1'b0;
    end else begin
      lp_q     <= lp_d;
      lp_cnt_q <= lp_cnt_d;
      test_q   <= test_d;
    end
  end

  assign io.btn_pulse  = pulse_q;
  assign io.btn_level  = ~stb_q[3:0];
  assign io.sns_level  = stb_q[7:5];
  assign io.sns_change = chg_q;
  assign io.test       = test_q;
endmodule

// File: tb/tb_entrada_condicionador.sv
// Bench for entrada_condicionador: directed steps plus random toggling,
// every cycle compared with a window-based behavioural model.
module tb_entrada_condicionador;
  localparam int DB = 4;
  localparam int LP = 20;
  localparam int RP = 10;
  localparam logic [7:0] IDLE_V = 8'h1F;

  logic clk = 1'b0;
  logic rst = 1'b0;

  entrada_condicionador_if bus ();

  entrada_condicionador #(
    .CLK_HZ       (1000),
    .DEBOUNCE_MS  (4),
    .LONG_PRESS_MS(20),
    .REPEAT_MS    (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] hq[$];
  logic [7:0] m_lvl;
  logic [3:0] m_pulse;
  logic [2:0] m_chg;
  logic       m_test;
  int         hold;
  int         age[2];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    m_lvl   = IDLE_V;
    m_pulse = '0;
    m_chg   = '0;
    m_test  = 1'b0;
    hold    = 0;
    age[0]  = 0;
    age[1]  = 0;
  endtask

  function automatic logic [7:0] hist(input int k);
    if (k < 0) return IDLE_V;
    return hq[k];
  endfunction

  // A channel accepts value v when the raw samples taken at edges
  // t-DB-1 .. t-2 (the synchroniser delay) all read v.
  task automatic model_edge();
    logic [7:0] prev, refv, w;
    logic same;
    int t;
    prev = m_lvl;
    t = hq.size();
    hq.push_back({bus.sns_raw, bus.btn_test_raw, bus.btn_raw});
    refv = hist(t - 2);
    for (int c = 0; c < 8; c++) begin
      same = 1'b1;
      for (int k = 2; k <= DB + 1; k++) begin
        w = hist(t - k);
        if (w[c] != refv[c]) same = 1'b0;
      end
      if (same && refv[c] != m_lvl[c]) m_lvl[c] = refv[c];
    end
    m_pulse = prev[3:0] & ~m_lvl[3:0];
`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < 2; i++) begin
      if (!prev[i] && !m_lvl[i]) begin
        age[i]++;
        if (age[i] % RP == 0) m_pulse[i] = 1'b1;
      end else begin
        age[i] = 0;
      end
    end
`endif
    m_chg = prev[7:5] ^ m_lvl[7:5];
    if (!prev[4]) begin
      hold++;
      if (hold == LP + 1) m_test = ~m_test;
    end else begin
      hold = 0;
    end
  endtask

  task automatic tick();
    logic [3:0] lv;
    @(posedge clk);
    if (rst) model_edge();
    else model_reset();
    #1;
    lv = ~m_lvl[3:0];
    check("btn_pulse", bus.btn_pulse, m_pulse);
    check("btn_level", bus.btn_level, lv);
    check("sns_level", bus.sns_level, m_lvl[7:5]);
    check("sns_change", bus.sns_change, m_chg);
    check("test", bus.test, m_test);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n, first, second, tg;
    int pc[4];
    logic pt;
    int ch;

    bus.btn_raw      = 4'hF;
    bus.btn_test_raw = 1'b1;
    bus.sns_raw      = 3'b000;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    check("rst_btn_pulse", bus.btn_pulse, 0);
    check("rst_btn_level", bus.btn_level, 0);
    check("rst_sns_level", bus.sns_level, 0);
    check("rst_test", bus.test, 0);
    repeat (4) tick();

    // Clean press on next.
    bus.btn_raw[1] = 1'b0;
    n = 0;
    first = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.btn_pulse[1]) begin
        n++;
        if (first < 0) first = c;
      end
      if (c == 7) check("press_pulse_c7", bus.btn_pulse[1], 0);
    end
    check("press_pulse_cycle", first, 6);
    check("press_pulse_count", n, 1);
    check("press_level", bus.btn_level[1], 1);
    bus.btn_raw[1] = 1'b1;
    repeat (10) tick();

    // Bouncing back button.
    n = 0;
    first = -1;
    for (int p = 0; p < 6; p++) begin
      bus.btn_raw[0] = p[0];
      repeat (2) begin
        tick();
        if (bus.btn_pulse[0]) n++;
      end
    end
    bus.btn_raw[0] = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.btn_pulse[0]) begin
        n++;
        if (first < 0) first = c;
      end
    end
    check("bounce_pulse_count", n, 1);
    check("bounce_pulse_cycle", first, 6);
    bus.btn_raw[0] = 1'b1;
    repeat (10) tick();

    // Sensor glitch then a real 10-cycle pulse.
    n = 0;
    bus.sns_raw[1] = 1'b1;
    repeat (3) begin
      tick();
      if (bus.sns_change[1]) n++;
    end
    bus.sns_raw[1] = 1'b0;
    repeat (10) begin
      tick();
      if (bus.sns_change[1]) n++;
    end
    check("sns_glitch_changes", n, 0);
    n = 0;
    first = -1;
    second = -1;
    bus.sns_raw[1] = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      if (c == 11) bus.sns_raw[1] = 1'b0;
      tick();
      if (bus.sns_change[1]) begin
        n++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    check("sns_change_count", n, 2);
    check("sns_rise_cycle", first, 6);
    check("sns_fall_cycle", second, 16);

    // Long press, short press, long press.
    tg = 0;
    pt = bus.test;
    bus.btn_test_raw = 1'b0;
    repeat (40) begin
      tick();
      if (bus.test !== pt) tg++;
      pt = bus.test;
    end
    bus.btn_test_raw = 1'b1;
    repeat (10) begin
      tick();
      if (bus.test !== pt) tg++;
      pt = bus.test;
    end
    check("lp_toggles", tg, 1);
    check("lp_test_on", bus.test, 1);
    bus.btn_test_raw = 1'b0;
    repeat (10) tick();
    bus.btn_test_raw = 1'b1;
    repeat (10) tick();
    check("short_test_kept", bus.test, 1);
    bus.btn_test_raw = 1'b0;
    repeat (40) tick();
    bus.btn_test_raw = 1'b1;
    repeat (10) tick();
    check("lp2_test_off", bus.test, 0);

    // Held next and comer buttons, 35 cycles after the press pulse.
    for (int b = 1; b <= 2; b++) begin
      n = 0;
      second = -1;
      bus.btn_raw[b] = 1'b0;
      for (int c = 1; c <= 50; c++) begin
        if (c == 36) bus.btn_raw[b] = 1'b1;
        tick();
        if (bus.btn_pulse[b]) begin
          n++;
          second = c;
        end
      end
`ifdef AUTO_REPEAT_EN
      if (b == 1) begin
        check("rep_next_count", n, 4);
        check("rep_next_last", second, 36);
      end else begin
        check("rep_comer_count", n, 1);
      end
`else
      check("hold_pulse_count", n, 1);
`endif
      repeat (5) tick();
    end

    // Reset in mid-operation with everything held.
    bus.btn_raw      = 4'h0;
    bus.btn_test_raw = 1'b0;
    bus.sns_raw      = 3'b101;
    repeat (30) tick();
    check("pre_rst_test", bus.test, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_btn_pulse", bus.btn_pulse, 0);
    check("async_btn_level", bus.btn_level, 0);
    check("async_sns_level", bus.sns_level, 0);
    check("async_sns_change", bus.sns_change, 0);
    check("async_test", bus.test, 0);
    bus.btn_test_raw = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    for (int b = 0; b < 4; b++) pc[b] = 0;
    repeat (12) begin
      tick();
      for (int b = 0; b < 4; b++) if (bus.btn_pulse[b]) pc[b]++;
    end
    for (int b = 0; b < 4; b++) check($sformatf("post_rst_pulse%0d", b), pc[b], 1);
    bus.btn_raw = 4'hF;
    bus.sns_raw = 3'b000;
    repeat (10) tick();

    // Random toggling against the model.
    for (int it = 0; it < 250; it++) begin
      ch = $urandom_range(7, 0);
      if (ch < 4) bus.btn_raw[ch] = ~bus.btn_raw[ch];
      else if (ch == 4) bus.btn_test_raw = ~bus.btn_test_raw;
      else bus.sns_raw[ch-5] = ~bus.sns_raw[ch-5];
      repeat ($urandom_range((ch == 4) ? 30 : 8, 1)) tick();
    end
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
